// File: rtl/cache_pkg.sv
// Shared widths, FSM encoding and address-field helpers for the direct-mapped
// write-through data cache controller.
package cache_pkg;
    localparam int ADDR_W  = 10;
    localparam int INDEX_W = 5;
    localparam int OFFS_W  = 2;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W;
    localparam int CADDR_W = INDEX_W + OFFS_W;
    localparam int DATA_W  = 32;
    localparam int LINES   = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WMEM   = 2'd2
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFS_W +: INDEX_W];
    endfunction

    function automatic logic [CADDR_W-1:0] addr_caddr(input logic [ADDR_W-1:0] a);
        return a[CADDR_W-1:0];
    endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, cache_data and main-memory signals of the cache controller.
interface cache_ctrl_if;
    import cache_pkg::*;

    logic                 cpu_rd;
    logic                 cpu_wr;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [DATA_W-1:0]    cpu_wd;
    logic [DATA_W-1:0]    cpu_rdata;
    logic                 stall;
    logic                 c_we;
    logic [CADDR_W-1:0]   c_r_addrs;
    logic [CADDR_W-1:0]   c_w_addrs;
    logic [DATA_W-1:0]    c_wd;
    logic [DATA_W-1:0]    c_rd;
    logic                 mem_rd_req;
    logic                 mem_wr_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wd;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 mem_ready;

    modport master (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wd, c_rd, mem_rdata, mem_ready,
        output cpu_rdata, stall, c_we, c_r_addrs, c_w_addrs, c_wd,
               mem_rd_req, mem_wr_req, mem_addr, mem_wd
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wd, c_rd, mem_rdata, mem_ready,
        input  cpu_rdata, stall, c_we, c_r_addrs, c_w_addrs, c_wd,
               mem_rd_req, mem_wr_req, mem_addr, mem_wd
    );
endinterface

// File: rtl/cache_tag_array.sv
// Per-line tag and valid storage: synchronous write, combinational read,
// all lines invalidated by reset.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] widx_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic [INDEX_W-1:0] ridx_i,
    output logic               valid_o,
    output logic [TAG_W-1:0]   tag_o
);
    logic [LINES-1:0]            valid_q;
    logic [LINES-1:0][TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
            tag_q[widx_i]   <= wtag_i;
        end
    end

    assign valid_o = valid_q[ridx_i];
    assign tag_o   = tag_q[ridx_i];
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate, read-allocate cache
// controller with 4-word block refill.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.master bus
);
    state_e              state_q, state_d;
    logic [OFFS_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wdone_q, wdone_d;

    logic                tag_we, line_valid, hit, wr_req, rd_req;
    logic [TAG_W-1:0]    line_tag;

    cache_tag_array u_tags (
        .clk     (clk),
        .rst     (rst),
        .we_i    (tag_we),
        .widx_i  (addr_index(addr_q)),
        .wtag_i  (addr_tag(addr_q)),
        .ridx_i  (addr_index(bus.cpu_addr)),
        .valid_o (line_valid),
        .tag_o   (line_tag)
    );

    assign hit    = line_valid && (line_tag == addr_tag(bus.cpu_addr));
    // The cycle after a memory write completes the CPU may still present the
    // same store; drop it so memory is not written twice.
    assign wr_req = bus.cpu_wr && !wdone_q;
    assign rd_req = bus.cpu_rd && !bus.cpu_wr;

    assign bus.c_r_addrs = addr_caddr(bus.cpu_addr);
    assign bus.cpu_rdata = bus.c_rd;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wdone_d        = 1'b0;
        tag_we         = 1'b0;
        bus.stall      = 1'b0;
        bus.c_we       = 1'b0;
        bus.c_w_addrs  = '0;
        bus.c_wd       = '0;
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wd     = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (wr_req) begin
                        bus.stall = 1'b1;
                        addr_d    = bus.cpu_addr;
                        wdata_d   = bus.cpu_wd;
                        state_d   = WMEM;
                        if (hit) begin
                            bus.c_we      = 1'b1;
                            bus.c_w_addrs = addr_caddr(bus.cpu_addr);
                            bus.c_wd      = bus.cpu_wd;
                        end
                    end else if (rd_req && !hit) begin
                        bus.stall = 1'b1;
                        addr_d    = {bus.cpu_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                        state_d   = REFILL;
                    end
                end
                REFILL: begin
                    bus.stall      = 1'b1;
                    bus.mem_rd_req = 1'b1;
                    bus.mem_addr   = addr_q;
                    if (bus.mem_ready) begin
                        bus.c_we      = 1'b1;
                        bus.c_w_addrs = {addr_index(addr_q), cnt_q};
                        bus.c_wd      = bus.mem_rdata;
                        cnt_d         = cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            tag_we  = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
                WMEM: begin
                    bus.stall      = 1'b1;
                    bus.mem_wr_req = 1'b1;
                    bus.mem_addr   = addr_q;
                    bus.mem_wd     = wdata_q;
                    if (bus.mem_ready) begin
                        wdone_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wdone_q <= wdone_d;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: cycle table for refill/hit/write traffic,
// plus hand sequences for line conflict and reset during refill.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cache_ctrl_if bus();
    cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    // cache_data word array: written on negedge, read combinationally
    logic [31:0] cmem [128];
    always @(negedge clk) if (bus.c_we) cmem[bus.c_w_addrs] <= bus.c_wd;
    assign bus.c_rd = cmem[bus.c_r_addrs];

    typedef struct {
        logic rd, wr; logic [9:0] addr; logic [31:0] wd; logic rdy; logic [31:0] md;
        logic e_stall, e_cwe; logic [6:0] e_cwa; logic [31:0] e_cwd;
        logic e_mrd, e_mwr; logic [9:0] e_maddr; logic [31:0] e_mwd;
        logic chk_rd; logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic rd, wr, input logic [9:0] addr, input logic [31:0] wd,
        input logic rdy, input logic [31:0] md,
        input logic st, cwe, input logic [6:0] cwa, input logic [31:0] cwd,
        input logic mrd, mwr, input logic [9:0] maddr, input logic [31:0] mwd,
        input logic chk, input logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.rdy = rdy; v.md = md;
        v.e_stall = st; v.e_cwe = cwe; v.e_cwa = cwa; v.e_cwd = cwd;
        v.e_mrd = mrd; v.e_mwr = mwr; v.e_maddr = maddr; v.e_mwd = mwd;
        v.chk_rd = chk; v.e_rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    // one clock: drive just after posedge, leave outputs to settle past negedge
    task automatic cyc(input logic rs, r, w, input logic [9:0] a, input logic [31:0] d,
                       input logic rdy, input logic [31:0] md);
        @(posedge clk); #1;
        rst = rs; bus.cpu_rd = r; bus.cpu_wr = w; bus.cpu_addr = a; bus.cpu_wd = d;
        bus.mem_ready = rdy; bus.mem_rdata = md;
        #5;
    endtask

    vec_t v [23];

    initial begin
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wd = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;

        // 0x044: tag 0, index 17, offset 0 -> cache words 0x44..0x47
        v[0]  = mk(1,0,10'h044,0,0,0,            1,0,0,0,            0,0,0,0,            0,0);
        v[1]  = mk(1,0,10'h044,0,0,0,            1,0,0,0,            1,0,10'h044,0,      0,0);
        v[2]  = mk(1,0,10'h044,0,1,32'hA0,       1,1,7'h44,32'hA0,   1,0,10'h044,0,      0,0);
        v[3]  = mk(1,0,10'h044,0,0,0,            1,0,0,0,            1,0,10'h044,0,      0,0);
        v[4]  = mk(1,0,10'h044,0,1,32'hA1,       1,1,7'h45,32'hA1,   1,0,10'h044,0,      0,0);
        v[5]  = mk(1,0,10'h044,0,1,32'hA2,       1,1,7'h46,32'hA2,   1,0,10'h044,0,      0,0);
        v[6]  = mk(1,0,10'h044,0,1,32'hA3,       1,1,7'h47,32'hA3,   1,0,10'h044,0,      0,0);
        v[7]  = mk(1,0,10'h044,0,0,0,            0,0,0,0,            0,0,0,0,            1,32'hA0);
        v[8]  = mk(1,0,10'h046,0,0,0,            0,0,0,0,            0,0,0,0,            1,32'hA2);
        v[9]  = mk(0,1,10'h045,32'hDEADBEEF,0,0, 1,1,7'h45,32'hDEADBEEF, 0,0,0,0,        0,0);
        v[10] = mk(0,1,10'h045,32'hDEADBEEF,0,0, 1,0,0,0,            0,1,10'h045,32'hDEADBEEF, 0,0);
        v[11] = mk(0,1,10'h045,32'hDEADBEEF,0,0, 1,0,0,0,            0,1,10'h045,32'hDEADBEEF, 0,0);
        v[12] = mk(0,1,10'h045,32'hDEADBEEF,1,0, 1,0,0,0,            0,1,10'h045,32'hDEADBEEF, 0,0);
        v[13] = mk(0,1,10'h045,32'hDEADBEEF,0,0, 0,0,0,0,            0,0,0,0,            1,32'hDEADBEEF);
        v[14] = mk(1,0,10'h045,0,0,0,            0,0,0,0,            0,0,0,0,            1,32'hDEADBEEF);
        v[15] = mk(0,1,10'h3C5,32'h12345678,0,0, 1,0,0,0,            0,0,0,0,            0,0);
        v[16] = mk(0,1,10'h3C5,32'h12345678,1,0, 1,0,0,0,            0,1,10'h3C5,32'h12345678, 0,0);
        v[17] = mk(0,0,10'h000,0,0,0,            0,0,0,0,            0,0,0,0,            0,0);
        v[18] = mk(1,0,10'h044,0,0,0,            0,0,0,0,            0,0,0,0,            1,32'hA0);
        v[19] = mk(1,1,10'h046,32'h55AA55AA,0,0, 1,1,7'h46,32'h55AA55AA, 0,0,0,0,        0,0);
        v[20] = mk(1,1,10'h046,32'h55AA55AA,1,0, 1,0,0,0,            0,1,10'h046,32'h55AA55AA, 0,0);
        v[21] = mk(0,0,10'h000,0,0,0,            0,0,0,0,            0,0,0,0,            0,0);
        v[22] = mk(1,0,10'h046,0,0,0,            0,0,0,0,            0,0,0,0,            1,32'h55AA55AA);

        // reset state
        cyc(1,0,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0);
        chk("rst_stall", 0, 32'(bus.stall), 0);
        chk("rst_cwe",   0, 32'(bus.c_we), 0);
        chk("rst_mrd",   0, 32'(bus.mem_rd_req), 0);
        chk("rst_mwr",   0, 32'(bus.mem_wr_req), 0);
        chk("rst_maddr", 0, 32'(bus.mem_addr), 0);

        for (int i = 0; i < 23; i++) begin
            cyc(0, v[i].rd, v[i].wr, v[i].addr, v[i].wd, v[i].rdy, v[i].md);
            chk("stall", i, 32'(bus.stall), 32'(v[i].e_stall));
            chk("c_we",  i, 32'(bus.c_we),  32'(v[i].e_cwe));
            chk("mrd",   i, 32'(bus.mem_rd_req), 32'(v[i].e_mrd));
            chk("mwr",   i, 32'(bus.mem_wr_req), 32'(v[i].e_mwr));
            chk("craddr", i, 32'(bus.c_r_addrs), 32'(v[i].addr[6:0]));
            if (v[i].e_cwe) begin
                chk("c_wa", i, 32'(bus.c_w_addrs), 32'(v[i].e_cwa));
                chk("c_wd", i, bus.c_wd, v[i].e_cwd);
            end
            if (v[i].e_mrd || v[i].e_mwr) chk("maddr", i, 32'(bus.mem_addr), 32'(v[i].e_maddr));
            if (v[i].e_mwr) chk("mwd", i, bus.mem_wd, v[i].e_mwd);
            if (v[i].chk_rd) chk("rdata", i, bus.cpu_rdata, v[i].e_rdata);
        end

        // conflict: 0x3C4 (tag 7, index 17) evicts the 0x044 line
        cyc(0,1,0,10'h3C4,0,0,0);
        chk("cf_miss", 0, 32'(bus.stall), 1);
        cyc(0,1,0,10'h3C4,0,0,0);
        chk("cf_mrd", 0, 32'(bus.mem_rd_req), 1);
        chk("cf_maddr", 0, 32'(bus.mem_addr), 32'h3C4);
        for (int j = 0; j < 4; j++) begin
            cyc(0,1,0,10'h3C4,0,1,32'hB0 + 32'(j));
            chk("cf_cwe", j, 32'(bus.c_we), 1);
            chk("cf_cwa", j, 32'(bus.c_w_addrs), 32'h44 + 32'(j));
        end
        cyc(0,1,0,10'h3C4,0,0,0);
        chk("cf_hit", 0, 32'(bus.stall), 0);
        chk("cf_rdata", 0, bus.cpu_rdata, 32'hB0);
        cyc(0,1,0,10'h044,0,0,0);
        chk("cf_old_miss", 0, 32'(bus.stall), 1);

        // reset after two of four refill words
        cyc(0,1,0,10'h044,0,0,0);
        chk("rr_mrd", 0, 32'(bus.mem_rd_req), 1);
        cyc(0,1,0,10'h044,0,1,32'hC0);
        cyc(0,1,0,10'h044,0,1,32'hC1);
        chk("rr_cwa1", 0, 32'(bus.c_w_addrs), 32'h45);
        cyc(1,1,0,10'h044,0,0,0);
        chk("rr_stall", 0, 32'(bus.stall), 0);
        chk("rr_mrd0", 0, 32'(bus.mem_rd_req), 0);
        cyc(0,1,0,10'h044,0,0,0);
        chk("rr_remiss", 0, 32'(bus.stall), 1);
        chk("rr_mrd_idle", 0, 32'(bus.mem_rd_req), 0);
        for (int j = 0; j < 4; j++) begin
            cyc(0,1,0,10'h044,0,1,32'hD0 + 32'(j));
            chk("rr_mrd_ref", j, 32'(bus.mem_rd_req), 1);
            chk("rr_cwa", j, 32'(bus.c_w_addrs), 32'h44 + 32'(j));
        end
        cyc(0,1,0,10'h044,0,0,0);
        chk("rr_hit", 0, 32'(bus.stall), 0);
        chk("rr_rdata", 0, bus.cpu_rdata, 32'hD0);
        cyc(0,1,0,10'h047,0,0,0);
        chk("rr_rdata3", 0, bus.cpu_rdata, 32'hD3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
